data_mem_dp: RTL and testbench

//  Parametrised two-port data memory for the pipeline MEM stage: main port (load/store) + companion port (_c).

---
 rtl/data_mem_pkg.sv | 31 +++
 rtl/data_mem_dp_if.sv | 25 ++
 rtl/data_mem_init_seq.sv | 63 ++++++
 rtl/data_mem_dp.sv | 141 ++++++++++++++
 tb/tb_data_mem_dp.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the two-port MEM-stage data memory.
// Optional feature macro used by the top: DATA_MEM_BYPASS_EN.
package data_mem_pkg;

    typedef enum logic {
        DM_INIT  = 1'b0,
        DM_READY = 1'b1
    } dm_state_t;

    // Widest word be_merge can handle; callers zero-extend into it and
    // truncate the result back to their own width.
    localparam int DM_MAX_W  = 512;
    localparam int DM_MAX_NB = DM_MAX_W / 8;

    // Replace the bytes of old_w selected by be with the matching bytes of new_w.
    function automatic logic [DM_MAX_W-1:0] be_merge(
        input logic [DM_MAX_W-1:0]  old_w,
        input logic [DM_MAX_W-1:0]  new_w,
        input logic [DM_MAX_NB-1:0] be
    );
        logic [DM_MAX_W-1:0] res;
        res = old_w;
        for (int k = 0; k < DM_MAX_NB; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_dp_if.sv
// One memory access port: request from the pipeline, registered read reply.
// The top takes two of these, one for the main port and one for the companion.
interface data_mem_dp_if #(
    parameter int DATA_W = 32
) ();
    localparam int NB = DATA_W / 8;

    logic              mem_rd;
    logic              mem_wr;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output mem_rd, mem_wr, addr, wdata, be,
        input  rdata, rvalid
    );

    modport slave (
        input  mem_rd, mem_wr, addr, wdata, be,
        output rdata, rvalid
    );
endinterface

// File: rtl/data_mem_init_seq.sv
// Post-reset initialisation sequencer: walks every word once, one per cycle,
// presenting INIT_BASE + idx*INIT_STEP, then parks in DM_READY.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   DM_INIT  | writing word init_idx; port requests are dropped
//   DM_READY | initialisation done; memory serves both ports
module data_mem_init_seq
    import data_mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int INIT_BASE = 0,
    parameter int INIT_STEP = 4,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_busy,
    output logic              init_we,
    output logic [AW-1:0]     init_idx,
    output logic [DATA_W-1:0] init_data
);

    dm_state_t     state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    // State and word counter; reset always restarts the walk at word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DM_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Advance one word per cycle; leave INIT on the cycle that writes the last word.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        init_we = 1'b0;
        case (state_q)
            DM_INIT: begin
                init_we = 1'b1;
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = DM_READY;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            DM_READY: ;
            default: state_d = DM_INIT;
        endcase
    end

    assign init_busy = (state_q == DM_INIT);
    assign init_idx  = idx_q;
    assign init_data = DATA_W'(INIT_BASE) + DATA_W'(idx_q) * DATA_W'(INIT_STEP);

endmodule

// File: rtl/data_mem_dp.sv
// Two-port data memory for the MEM stage (main + companion port).
// Byte-lane writes, registered reads, main-port priority on write collisions,
// misaligned-request flagging and a sequenced post-reset fill.
// Build option: define DATA_MEM_BYPASS_EN for write-first read-during-write;
// otherwise reads return the word as it was before this cycle's writes.
module data_mem_dp
    import data_mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int INIT_BASE = 0,
    parameter int INIT_STEP = 4
) (
    input  logic            clk,
    input  logic            reset,
    data_mem_dp_if.slave    bus_m,
    data_mem_dp_if.slave    bus_c,
    output logic            init_busy,
    output logic [1:0]      misalign
);

    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(DEPTH);

    logic              init_we;
    logic [AW-1:0]     init_idx;
    logic [DATA_W-1:0] init_data;

    data_mem_init_seq #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_BASE (INIT_BASE),
        .INIT_STEP (INIT_STEP),
        .AW        (AW)
    ) u_init_seq (
        .clk       (clk),
        .reset     (reset),
        .init_busy (init_busy),
        .init_we   (init_we),
        .init_idx  (init_idx),
        .init_data (init_data)
    );

    function automatic logic [DATA_W-1:0] merge_word(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     lanes
    );
        return DATA_W'(be_merge(DM_MAX_W'(old_w), DM_MAX_W'(new_w), DM_MAX_NB'(lanes)));
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [DATA_W-1:0] rdata_q, rdata_d, rdata_c_q, rdata_c_d;
    logic              rvalid_q, rvalid_d, rvalid_c_q, rvalid_c_d;
    logic [1:0]        misalign_q, misalign_d;

    logic          ready;
    logic [AW-1:0] idx_m, idx_c;
    logic          mis_m, mis_c;
    logic          we_m, we_c, re_m, re_c;
    logic [DATA_W-1:0] word_m, word_c;

    // Index wraps modulo DEPTH: address bits above the word index are don't-care.
    logic addr_hi_unused;
    assign addr_hi_unused = ^{bus_m.addr[31:AW+2], bus_c.addr[31:AW+2]};

    assign ready = ~init_busy;
    assign idx_m = bus_m.addr[AW+1:2];
    assign idx_c = bus_c.addr[AW+1:2];

    // A misaligned request is dropped whole (no write, no read) and only flagged.
    assign mis_m = ready && (bus_m.mem_rd || bus_m.mem_wr) && (bus_m.addr[1:0] != 2'b00);
    assign mis_c = ready && (bus_c.mem_rd || bus_c.mem_wr) && (bus_c.addr[1:0] != 2'b00);
    assign we_m  = ready && bus_m.mem_wr && !mis_m;
    assign we_c  = ready && bus_c.mem_wr && !mis_c;
    assign re_m  = ready && bus_m.mem_rd && !mis_m;
    assign re_c  = ready && bus_c.mem_rd && !mis_c;

    // Next array image: init fill, then companion write, then main write on top,
    // so a same-word collision merges per byte with the main port winning.
    always_comb begin
        mem_d = mem_q;
        if (init_we) begin
            mem_d[init_idx] = init_data;
        end
        if (we_c) begin
            mem_d[idx_c] = merge_word(mem_d[idx_c], bus_c.wdata, bus_c.be);
        end
        if (we_m) begin
            mem_d[idx_m] = merge_word(mem_d[idx_m], bus_m.wdata, bus_m.be);
        end
    end

`ifdef DATA_MEM_BYPASS_EN
    assign word_m = mem_d[idx_m];
    assign word_c = mem_d[idx_c];
`else
    assign word_m = mem_q[idx_m];
    assign word_c = mem_q[idx_c];
`endif

    // Read replies and misalign flags for the next cycle; idle ports return zero.
    always_comb begin
        rdata_d    = re_m ? word_m : '0;
        rdata_c_d  = re_c ? word_c : '0;
        rvalid_d   = re_m;
        rvalid_c_d = re_c;
        misalign_d = {mis_c, mis_m};
    end

    // Array storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q    <= '0;
            rdata_c_q  <= '0;
            rvalid_q   <= 1'b0;
            rvalid_c_q <= 1'b0;
            misalign_q <= 2'b00;
        end else begin
            rdata_q    <= rdata_d;
            rdata_c_q  <= rdata_c_d;
            rvalid_q   <= rvalid_d;
            rvalid_c_q <= rvalid_c_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus_m.rdata  = rdata_q;
    assign bus_m.rvalid = rvalid_q;
    assign bus_c.rdata  = rdata_c_q;
    assign bus_c.rvalid = rvalid_c_q;
    assign misalign     = misalign_q;

endmodule

// File: tb/tb_data_mem_dp.sv
// Bench for data_mem_dp (DATA_W=32, DEPTH=16, INIT_BASE=0, INIT_STEP=4).
// Directed table rows, init-length / reset-restart sequences, then random
// traffic compared every cycle against an array-based reference model.
module tb_data_mem_dp;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

`ifdef DATA_MEM_BYPASS_EN
    localparam logic [31:0] RDW_3C = 32'hDEADBEEF;
    localparam logic [31:0] RDW_24 = 32'h12345678;
    localparam logic [31:0] RDW_18 = 32'h99000018;
`else
    localparam logic [31:0] RDW_3C = 32'h0000003C;
    localparam logic [31:0] RDW_24 = 32'h00000024;
    localparam logic [31:0] RDW_18 = 32'h00000018;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       init_busy;
    logic [1:0] misalign;

    data_mem_dp_if #(.DATA_W(DW)) bus_m ();
    data_mem_dp_if #(.DATA_W(DW)) bus_c ();

    data_mem_dp #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .INIT_BASE (0),
        .INIT_STEP (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_m     (bus_m),
        .bus_c     (bus_c),
        .init_busy (init_busy),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        logic        rd_c, wr_c;
        logic [31:0] addr_c, wdata_c;
        logic [3:0]  be_c;
    } req_t;

    typedef struct {
        string       name;
        req_t        r;
        logic [31:0] e_rdata;
        logic        e_rvalid;
        logic [31:0] e_rdata_c;
        logic        e_rvalid_c;
        logic [1:0]  e_mis;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    int          init_left;
    logic [31:0] m_rdata, m_rdata_c;
    logic        m_rvalid, m_rvalid_c, m_busy;
    logic [1:0]  m_mis;

    function automatic req_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                                logic [3:0] be, logic rd_c, logic wr_c, logic [31:0] addr_c,
                                logic [31:0] wdata_c, logic [3:0] be_c);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wdata; r.be = be;
        r.rd_c = rd_c; r.wr_c = wr_c; r.addr_c = addr_c; r.wdata_c = wdata_c; r.be_c = be_c;
        return r;
    endfunction

    function automatic req_t idle_req();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t mkv(string name, req_t r, logic [31:0] er, logic ev,
                                 logic [31:0] erc, logic evc, logic [1:0] em);
        vec_t v;
        v.name = name; v.r = r; v.e_rdata = er; v.e_rvalid = ev;
        v.e_rdata_c = erc; v.e_rvalid_c = evc; v.e_mis = em;
        return v;
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] put_bytes(logic [31:0] w, logic [31:0] d, logic [3:0] be);
        logic [31:0] o;
        o = w;
        for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = d[8*b +: 8];
        return o;
    endfunction

    // Reference: one clock edge with request r held and reset rst.
    task automatic model_step(req_t r, logic rst);
        logic [31:0] old_mem [DEPTH];
        logic        mm, mc;
        int          im, ic;
        m_rdata = 0; m_rdata_c = 0; m_rvalid = 0; m_rvalid_c = 0; m_mis = 0;
        if (rst) begin
            init_left = DEPTH;
        end else if (init_left > 0) begin
            ref_mem[DEPTH - init_left] = 32'((DEPTH - init_left) * 4);
            init_left--;
        end else begin
            old_mem = ref_mem;
            mm = (r.rd || r.wr) && (r.addr % 4 != 0);
            mc = (r.rd_c || r.wr_c) && (r.addr_c % 4 != 0);
            im = int'((r.addr / 4) % DEPTH);
            ic = int'((r.addr_c / 4) % DEPTH);
            if (r.wr_c && !mc) ref_mem[ic] = put_bytes(ref_mem[ic], r.wdata_c, r.be_c);
            if (r.wr && !mm)   ref_mem[im] = put_bytes(ref_mem[im], r.wdata, r.be);
            m_mis = {mc, mm};
            if (r.rd && !mm) begin
                m_rvalid = 1;
`ifdef DATA_MEM_BYPASS_EN
                m_rdata = ref_mem[im];
`else
                m_rdata = old_mem[im];
`endif
            end
            if (r.rd_c && !mc) begin
                m_rvalid_c = 1;
`ifdef DATA_MEM_BYPASS_EN
                m_rdata_c = ref_mem[ic];
`else
                m_rdata_c = old_mem[ic];
`endif
            end
        end
        m_busy = (init_left > 0);
    endtask

    task automatic apply(req_t r, logic rst);
        bus_m.mem_rd = r.rd;   bus_m.mem_wr = r.wr;   bus_m.addr = r.addr;
        bus_m.wdata  = r.wdata; bus_m.be = r.be;
        bus_c.mem_rd = r.rd_c; bus_c.mem_wr = r.wr_c; bus_c.addr = r.addr_c;
        bus_c.wdata  = r.wdata_c; bus_c.be = r.be_c;
        reset = rst;
        @(posedge clk);
        #1;
        model_step(r, rst);
        check("model", 128'({bus_m.rdata, bus_m.rvalid, bus_c.rdata, bus_c.rvalid, misalign, init_busy}),
                       128'({m_rdata, m_rvalid, m_rdata_c, m_rvalid_c, m_mis, m_busy}));
    endtask

    task automatic run_row(vec_t v);
        apply(v.r, 1'b0);
        check(v.name, 128'({bus_m.rdata, bus_m.rvalid, bus_c.rdata, bus_c.rvalid, misalign, init_busy}),
                      128'({v.e_rdata, v.e_rvalid, v.e_rdata_c, v.e_rvalid_c, v.e_mis, 1'b0}));
    endtask

    // Count sampled cycles with init_busy high, bounded.
    task automatic count_busy(string name, req_t during);
        int n;
        n = 0;
        while (init_busy === 1'b1 && n < 40) begin
            n++;
            apply(during, 1'b0);
        end
        check(name, 128'(n), 128'(DEPTH));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        req_t r;
        init_left = DEPTH;

        tbl.push_back(mkv("rd_28",      mk(1,0,32'h28,0,0, 0,0,0,0,0), 32'h28, 1, 0, 0, 2'b00));
        tbl.push_back(mkv("wr_08_be5",  mk(0,1,32'h08,32'hAABBCCDD,4'b0101, 0,0,0,0,0), 0, 0, 0, 0, 2'b00));
        tbl.push_back(mkv("rd_08",      mk(1,0,32'h08,0,0, 0,0,0,0,0), 32'h00BB00DD, 1, 0, 0, 2'b00));
        tbl.push_back(mkv("collide_10", mk(0,1,32'h10,32'h11111111,4'b0011, 0,1,32'h10,32'h22222222,4'b0110), 0, 0, 0, 0, 2'b00));
        tbl.push_back(mkv("rd_10",      mk(1,0,32'h10,0,0, 0,0,0,0,0), 32'h00221111, 1, 0, 0, 2'b00));
        tbl.push_back(mkv("rdw_3c",     mk(1,1,32'h3C,32'hDEADBEEF,4'hF, 0,0,0,0,0), RDW_3C, 1, 0, 0, 2'b00));
        tbl.push_back(mkv("rd_3c",      mk(1,0,32'h3C,0,0, 0,0,0,0,0), 32'hDEADBEEF, 1, 0, 0, 2'b00));
        tbl.push_back(mkv("mis_rd_06",  mk(1,0,32'h06,0,0, 0,0,0,0,0), 0, 0, 0, 0, 2'b01));
        tbl.push_back(mkv("rd_44_wrap", mk(1,0,32'h44,0,0, 0,0,0,0,0), 32'h04, 1, 0, 0, 2'b00));
        tbl.push_back(mkv("mis_wr_c",   mk(0,0,0,0,0, 0,1,32'h01,32'hFFFFFFFF,4'hF), 0, 0, 0, 0, 2'b10));
        tbl.push_back(mkv("rd_c_00",    mk(0,0,0,0,0, 1,0,32'h00,0,0), 0, 0, 32'h0, 1, 2'b00));
        tbl.push_back(mkv("mis_m_rd_c", mk(1,0,32'h2B,0,0, 1,0,32'h28,0,0), 0, 0, 32'h28, 1, 2'b01));
        tbl.push_back(mkv("dual_rd",    mk(1,0,32'h10,0,0, 1,0,32'h2C,0,0), 32'h00221111, 1, 32'h2C, 1, 2'b00));
        tbl.push_back(mkv("wr_be0",     mk(0,1,32'h20,32'hFFFFFFFF,4'h0, 0,0,0,0,0), 0, 0, 0, 0, 2'b00));
        tbl.push_back(mkv("rd_20",      mk(1,0,32'h20,0,0, 0,0,0,0,0), 32'h20, 1, 0, 0, 2'b00));
        tbl.push_back(mkv("rdw_24",     mk(1,1,32'h24,32'h12345678,4'hF, 0,0,0,0,0), RDW_24, 1, 0, 0, 2'b00));
        tbl.push_back(mkv("rd_c_24",    mk(0,0,0,0,0, 1,0,32'h24,0,0), 0, 0, 32'h12345678, 1, 2'b00));
        tbl.push_back(mkv("rdw_x_18",   mk(1,0,32'h18,0,0, 0,1,32'h18,32'h99000000,4'b1000), RDW_18, 1, 0, 0, 2'b00));
        tbl.push_back(mkv("rd_18",      mk(1,0,32'h18,0,0, 0,0,0,0,0), 32'h99000018, 1, 0, 0, 2'b00));
        tbl.push_back(mkv("idle",       idle_req(), 0, 0, 0, 0, 2'b00));

        // Reset and first initialisation.
        apply(idle_req(), 1'b1);
        check("reset_outs", 128'({bus_m.rdata, bus_m.rvalid, bus_c.rdata, bus_c.rvalid, misalign, init_busy}),
                            128'({32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b1}));
        count_busy("init_len", mk(1,0,32'h06,0,0, 1,0,32'h04,0,0));

        foreach (tbl[i]) run_row(tbl[i]);

        // Reset during init (cycle 7): restart, writes during init are ignored.
        apply(idle_req(), 1'b1);
        for (int i = 0; i < 7; i++) apply(mk(0,1,32'h08,32'hFFFFFFFF,4'hF, 0,0,0,0,0), 1'b0);
        apply(idle_req(), 1'b1);
        count_busy("init_restart_len", mk(0,1,32'h0C,32'hFFFFFFFF,4'hF, 0,1,32'h08,32'hFFFFFFFF,4'hF));
        run_row(mkv("post_init_0c", mk(1,0,32'h0C,0,0, 1,0,32'h08,0,0), 32'h0C, 1, 32'h08, 1, 2'b00));

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r.rd = 1'($urandom); r.wr = 1'($urandom);
            r.addr = $urandom; r.wdata = $urandom; r.be = 4'($urandom);
            r.rd_c = 1'($urandom); r.wr_c = 1'($urandom);
            r.addr_c = $urandom; r.wdata_c = $urandom; r.be_c = 4'($urandom);
            if ($urandom_range(3) == 0) r.addr_c = r.addr;
            if ($urandom_range(7) != 0) r.addr[1:0] = 2'b00;
            if ($urandom_range(7) != 0) r.addr_c[1:0] = 2'b00;
            apply(r, ($urandom_range(399) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
